// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing front-end: opcodes, FSM states
// and flag-register bit positions.
package alu_pkg;

    localparam int OP_W = 4;
    localparam int FR_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SLT = 4'h2;
    localparam logic [OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [OP_W-1:0] OP_OR  = 4'h6;
    localparam logic [OP_W-1:0] OP_AND = 4'h7;
    localparam logic [OP_W-1:0] OP_SUB = 4'h8;

    localparam int FR_ZF = 3;
    localparam int FR_CF = 2;
    localparam int FR_OF = 1;
    localparam int FR_SF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SLT, OP_XOR, OP_OR, OP_AND, OP_SUB: is_legal_op = 1'b1;
            default:                                       is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: ADD, SUB, SLT, XOR, OR, AND with ZF/CF/OF/SF.
// CF is carry-out on ADD and borrow on SUB; illegal opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [OP_W-1:0]   ALU_OP,
    input  logic [DATA_W-1:0] ALU_A,
    input  logic [DATA_W-1:0] ALU_B,
    output logic [DATA_W-1:0] ALU_F,
    output logic              ZF,
    output logic              CF,
    output logic              OF,
    output logic              SF
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] w_wide;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_wide = '0;
        ALU_F  = '0;
        CF     = 1'b0;
        OF     = 1'b0;
        case (ALU_OP)
            OP_ADD: begin
                w_wide = {1'b0, ALU_A} + {1'b0, ALU_B};
                ALU_F  = w_wide[MSB:0];
                CF     = w_wide[DATA_W];
                OF     = (ALU_A[MSB] == ALU_B[MSB]) && (ALU_F[MSB] != ALU_A[MSB]);
            end
            OP_SUB: begin
                w_wide = {1'b0, ALU_A} - {1'b0, ALU_B};
                ALU_F  = w_wide[MSB:0];
                CF     = w_wide[DATA_W];
                OF     = (ALU_A[MSB] != ALU_B[MSB]) && (ALU_F[MSB] != ALU_A[MSB]);
            end
            OP_SLT:  ALU_F = {{(DATA_W-1){1'b0}}, ($signed(ALU_A) < $signed(ALU_B))};
            OP_XOR:  ALU_F = ALU_A ^ ALU_B;
            OP_OR:   ALU_F = ALU_A | ALU_B;
            OP_AND:  ALU_F = ALU_A & ALU_B;
            default: ALU_F = '0;
        endcase
        ZF = (ALU_F == '0);
        SF = ALU_F[MSB];
    end

endmodule

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port
// fed from either write-back or the host, r0 reads as zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [DATA_W-1:0] i_ext_wdata
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // The two sources are never active together (WB vs IDLE), so the priority is arbitrary.
    assign w_we    = i_wb_we | i_ext_we;
    assign w_waddr = i_wb_we ? i_wb_addr : i_ext_addr;
    assign w_wdata = i_wb_we ? i_wb_data : i_ext_wdata;

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

    always_ff @(posedge clk) begin
        // NOTE: the whole array is cleared on reset because the block must come up with
        // all registers at zero; this forces flops rather than a RAM macro.
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we && (w_waddr != '0)) begin
            // NOTE: non-blocking so reads in this cycle see the pre-write value.
            r_regs[w_waddr] <= w_wdata;
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencing front-end for the ALU: accepts register-addressed commands,
// drives the ALU from registers, captures result/flags and writes back.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [OP_W-1:0]   ALU_OP,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    input  logic [DATA_W-1:0] ALU_F,
    input  logic              ZF,
    input  logic              CF,
    input  logic              OF,
    input  logic              SF,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [FR_W-1:0]   ALU_FR
);

    state_t            r_state;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_result;
    logic [FR_W-1:0]   r_fr;
    logic              r_done;
    logic              r_err;
    logic              r_cmd_ready;
    logic [ADDR_W-1:0] r_rd;
    logic              r_illegal;

    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic              w_wb_we;
    logic              w_ext_we;

    assign w_wb_we  = (r_state == ST_WB) && !r_illegal;
    assign w_ext_we = (r_state == ST_IDLE) && ext_we;

    alu_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_raddr_a   (cmd_rs1),
        .i_raddr_b   (cmd_rs2),
        .o_rdata_a   (w_rdata_a),
        .o_rdata_b   (w_rdata_b),
        .i_wb_we     (w_wb_we),
        .i_wb_addr   (r_rd),
        .i_wb_data   (r_result),
        .i_ext_we    (w_ext_we),
        .i_ext_addr  (ext_addr),
        .i_ext_wdata (ext_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_result    <= '0;
            r_fr        <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rd        <= '0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_alu_a     <= w_rdata_a;
                        r_alu_b     <= w_rdata_b;
                        r_alu_op    <= cmd_op;
                        r_rd        <= cmd_rd;
                        r_illegal   <= !is_legal_op(cmd_op);
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= ALU_F;
                    if (!r_illegal) begin
                        r_fr[FR_ZF] <= ZF;
                        r_fr[FR_CF] <= CF;
                        r_fr[FR_OF] <= OF;
                        r_fr[FR_SF] <= SF;
                    end
                    // done/err are raised here so they are registered high throughout WB.
                    r_done  <= 1'b1;
                    r_err   <= r_illegal;
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign ALU_OP    = r_alu_op;
    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign ALU_FR    = r_fr;

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Sequencing front-end that sits directly upstream of the 32-bit combinational alu and consumes its result. It accepts register-addressed ALU commands over a valid/ready handshake and reads operands from an internal register file. It drives ALU_OP/ALU_A/ALU_B from registers, captures ALU_F and the ZF/CF/OF/SF flags, writes the result back, and reports completion.

Parameters:
DATA_W, 32, operand/result width (must match alu)
ADDR_W, 5, register address width; register file holds 2**ADDR_W entries, r0 hardwired to zero

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept command (high only in IDLE)
cmd_op  in  4  ALU opcode
cmd_rs1  in  ADDR_W  source A register
cmd_rs2  in  ADDR_W  source B register
cmd_rd  in  ADDR_W  destination register
ext_we  in  1  host register write (test/init)
ext_addr  in  ADDR_W  host write address
ext_wdata  in  DATA_W  host write data
ALU_OP  out  4  to alu, registered
ALU_A  out  DATA_W  to alu, registered
ALU_B  out  DATA_W  to alu, registered
ALU_F  in  DATA_W  from alu
ZF, CF, OF, SF  in  1 each  from alu
done  out  1  one-cycle completion pulse
err  out  1  valid with done: illegal opcode
result  out  DATA_W  captured ALU_F, valid with done, held afterwards
ALU_FR  out  4  flag register {ZF,CF,OF,SF}, bit3..bit0

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE; ALU_OP=0, ALU_A=0, ALU_B=0, result=0, ALU_FR=0, done=0, err=0, all registers=0. Reset mid-command aborts it: no write-back, no done.
- Legal opcodes: 0 ADD, 2 SLT, 4 XOR, 6 OR, 7 AND, 8 SUB. All others are illegal.
- FSM IDLE -> EXEC -> WB -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge k:
  - ALU_A<=reg[rs1], ALU_B<=reg[rs2], ALU_OP<=cmd_op.
  - Latch rd and the illegal indication.
  - Go to EXEC.
- EXEC (cycle k+1): the alu settles combinationally. At the edge:
  - result<=ALU_F.
  - If the opcode is legal, ALU_FR<={ZF,CF,OF,SF}; if illegal, ALU_FR is unchanged.
  - Go to WB.
- WB (cycle k+2): done=1, err=illegal. If legal and rd!=0, reg[rd]<=result at the edge. Go to IDLE; cmd_ready=1 in cycle k+3.
- Latency: done 2 cycles after acceptance. Throughput: 1 command per 3 cycles.
- Hazards: write-back completes before the next IDLE read, so no forwarding is needed.
- ALU_A/B/OP hold their last values outside EXEC. result and ALU_FR hold until the next update.
- Register reads are asynchronous. r0 always reads 0; writes to r0 from WB or ext are discarded.
- ext_we is honoured only in IDLE and ignored in EXEC/WB.
- If ext_we and a command handshake occur in the same IDLE cycle, both take effect; the command reads the pre-write value (read-before-write).
- cmd_* inputs are ignored while cmd_ready=0; commands are not queued.
- Arithmetic, wrap-around and flag semantics belong entirely to alu. This block captures them verbatim and applies no width extension.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants: OP_ADD=4'h0, OP_SLT=4'h2, OP_XOR=4'h4, OP_OR=4'h6, OP_AND=4'h7, OP_SUB=4'h8.
  - The FSM state encoding.
  - FR bit index constants: FR_ZF=3, FR_CF=2, FR_OF=1, FR_SF=0.
- One sub-module: alu_regfile (2 async read ports, 1 sync write port with a mux between the WB and ext sources, r0 forced to zero). It is instantiated once.
- The bench instantiates alu_exec_ctrl together with the real alu.

Test Plan:
- Basic AND: ext-write r1=0x00000003, r2=0x00000607; cmd AND rs1=1 rs2=2 rd=3 -> done 2 cycles after acceptance, result=0x00000003, err=0, ALU_FR[3]=0, r3 reads 0x00000003.
- Overflow ADD: r4=r5=0x80000000; ADD rd=6 -> result=0x00000000, ALU_FR=4'b1110, r6=0.
- Zero SUB: r7=r8=0x7FFFFFFF; SUB rd=9 -> result=0, ALU_FR[3]=1, ALU_FR[1]=0, ALU_FR[0]=0.
- Illegal/r0: op=4'h3 rd=3 -> done=1, err=1, r3 and ALU_FR unchanged. Then ADD r1+r2 rd=0 -> r0 still reads 0.
- Back-to-back and ext collision:
  - cmd_valid held high -> accepted at cycles 0, 3, 6; cmd_ready low in EXEC/WB.
  - ext_we to r1 in EXEC is ignored.
  - ext_we r1=5 in the same cycle as a cmd reading r1 -> the command uses the old value; r1=5 afterwards.
- Reset mid-op: rst=1 for one cycle during EXEC -> no done pulse, ALU_FR=0, result=0, cmd_ready=1 the cycle after rst deasserts.
